// File: rtl/fp32_stim_gen_if.sv
// rtl/fp32_stim_gen_if.sv - operand/control bundle between stimulus generator and multiplier bench
interface fp32_stim_gen_if;
   logic        start;
   logic        pause;
   logic [31:0] x1;
   logic [31:0] x2;
   logic        val;
   logic        over;
   logic        busy;
   logic [31:0] vec_cnt;

   modport master (
      input  start,
      input  pause,
      output x1,
      output x2,
      output val,
      output over,
      output busy,
      output vec_cnt
   );

   modport slave (
      output start,
      output pause,
      input  x1,
      input  x2,
      input  val,
      input  over,
      input  busy,
      input  vec_cnt
   );
endinterface

// File: rtl/fp32_stim_gen.sv
// rtl/fp32_stim_gen.sv - fp32 multiplier operand generator: directed corners, LFSR randoms, drain
module fp32_stim_gen #(
   parameter int          NUM_VECTORS = 1000000,
   parameter logic [31:0] SEED        = 32'h0000_0001,
   parameter int          EXP_BASE    = 95,
   parameter int          PIPE_LAT    = 4
) (
   input  logic            clk,
   input  logic            rst,
   fp32_stim_gen_if.master gen
);

   // A zero seed would lock a Galois LFSR at zero forever.
   localparam logic [31:0] SEED_A_RAW = SEED;
   localparam logic [31:0] SEED_B_RAW = SEED ^ 32'hFFFF_FFFF;
   localparam logic [31:0] SEED_A     = (SEED_A_RAW == 32'h0) ? 32'h1 : SEED_A_RAW;
   localparam logic [31:0] SEED_B     = (SEED_B_RAW == 32'h0) ? 32'h1 : SEED_B_RAW;
   localparam logic [31:0] NUM_V      = NUM_VECTORS[31:0];
   localparam bit          SHORT_RUN  = (NUM_VECTORS == 8);
   localparam logic [7:0]  EXP_B      = EXP_BASE[7:0];
   localparam logic [31:0] DRAIN_LAST = (PIPE_LAT > 1) ? 32'(PIPE_LAT - 1) : 32'd0;
   localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DIRECTED,
      S_RANDOM,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t      state;
   logic [2:0]  idx;
   logic [31:0] drain_cnt;
   logic [31:0] ra;
   logic [31:0] rb;

   // Corner cases: exact ones, small integers, sign mixes, mantissa carry-out,
   // sqrt(2) rounding, wide exponent spread, and near-max products.
   function automatic logic [63:0] dir_entry(input logic [2:0] i);
      logic [63:0] e;
      case (i)
         3'd0:    e = {32'h3F80_0000, 32'h3F80_0000};
         3'd1:    e = {32'h4000_0000, 32'h4040_0000};
         3'd2:    e = {32'hBFC0_0000, 32'h4000_0000};
         3'd3:    e = {32'hBF80_0000, 32'hBF80_0000};
         3'd4:    e = {32'h3FFF_FFFF, 32'h3FFF_FFFF};
         3'd5:    e = {32'h3FB5_04F3, 32'h3FB5_04F3};
         3'd6:    e = {32'h4F00_0000, 32'h3000_0000};
         default: e = {32'h5F7F_FFFF, 32'h5F7F_FFFF};
      endcase
      return e;
   endfunction

   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
   endfunction

   // Only 6 exponent bits are used so both operands stay in 95..158 and
   // the product exponent never overflows or goes denormal.
   function automatic logic [31:0] to_operand(input logic       sgn,
                                              input logic [5:0]  e,
                                              input logic [22:0] m);
      return {sgn, EXP_B + {2'b00, e}, m};
   endfunction

   // Run sequencer: all outputs registered, pause freezes generation state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         idx         <= 3'd0;
         drain_cnt   <= 32'd0;
         ra          <= SEED_A;
         rb          <= SEED_B;
         gen.x1      <= 32'd0;
         gen.x2      <= 32'd0;
         gen.val     <= 1'b0;
         gen.over    <= 1'b0;
         gen.busy    <= 1'b0;
         gen.vec_cnt <= 32'd0;
      end else begin
         case (state)
            S_IDLE: begin
               gen.val  <= 1'b0;
               gen.over <= 1'b0;
               gen.busy <= 1'b0;
               // busy is still high for the one cycle after DONE; start is ignored then.
               if (gen.start && !gen.busy) begin
                  state       <= S_DIRECTED;
                  gen.busy    <= 1'b1;
                  gen.vec_cnt <= 32'd0;
                  idx         <= 3'd0;
               end
            end

            S_DIRECTED: begin
               if (gen.pause) begin
                  gen.val <= 1'b0;
               end else begin
                  {gen.x1, gen.x2} <= dir_entry(idx);
                  gen.val          <= 1'b1;
                  gen.vec_cnt      <= gen.vec_cnt + 32'd1;
                  idx              <= idx + 3'd1;
                  if (idx == 3'd7) begin
                     drain_cnt <= 32'd0;
                     state     <= SHORT_RUN ? S_DRAIN : S_RANDOM;
                  end
               end
            end

            S_RANDOM: begin
               if (gen.pause) begin
                  gen.val <= 1'b0;
               end else begin
                  gen.x1      <= to_operand(ra[31], ra[28:23], ra[22:0]);
                  gen.x2      <= to_operand(rb[31], rb[28:23], rb[22:0]);
                  ra          <= lfsr_next(ra);
                  rb          <= lfsr_next(rb);
                  gen.val     <= 1'b1;
                  gen.vec_cnt <= gen.vec_cnt + 32'd1;
                  if (gen.vec_cnt + 32'd1 >= NUM_V) begin
                     drain_cnt <= 32'd0;
                     state     <= S_DRAIN;
                  end
               end
            end

            S_DRAIN: begin
               gen.val <= 1'b0;
               if (drain_cnt == DRAIN_LAST) begin
                  state <= S_DONE;
               end else begin
                  drain_cnt <= drain_cnt + 32'd1;
               end
            end

            S_DONE: begin
               gen.val  <= 1'b0;
               gen.over <= 1'b1;
               state    <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fp32_stim_gen.sv
// tb/tb_fp32_stim_gen.sv - randomized self-checking bench for fp32_stim_gen
module tb_fp32_stim_gen;

   localparam int N  = 20;
   localparam int PL = 4;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   fp32_stim_gen_if bus();

   fp32_stim_gen #(
      .NUM_VECTORS(N),
      .SEED(32'h0000_0001),
      .EXP_BASE(95),
      .PIPE_LAT(PL)
   ) dut (
      .clk(clk),
      .rst(rst),
      .gen(bus)
   );

   int checks = 0;
   int errors = 0;

   logic [31:0] dir_x1 [8] = '{32'h3F800000, 32'h40000000, 32'hBFC00000, 32'hBF800000,
                               32'h3FFFFFFF, 32'h3FB504F3, 32'h4F000000, 32'h5F7FFFFF};
   logic [31:0] dir_x2 [8] = '{32'h3F800000, 32'h40400000, 32'h40000000, 32'hBF800000,
                               32'h3FFFFFFF, 32'h3FB504F3, 32'h30000000, 32'h5F7FFFFF};

   logic [31:0] m_ra;
   logic [31:0] m_rb;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return (s >> 1) ^ (((s % 2) == 1) ? 32'h80200003 : 32'h0);
   endfunction

   function automatic logic [31:0] operand(input logic [31:0] r);
      int e;
      e = 95 + int'((r >> 23) % 64);
      return (r & 32'h8000_0000) | (32'(e) << 23) | (r & 32'h007F_FFFF);
   endfunction

   task automatic model_reset();
      m_ra = 32'h1;
      m_rb = 32'hFFFF_FFFE;
   endtask

   task automatic next_expected(input int idx, output logic [31:0] e1, output logic [31:0] e2);
      if (idx < 8) begin
         e1 = dir_x1[idx];
         e2 = dir_x2[idx];
      end else begin
         e1   = operand(m_ra);
         e2   = operand(m_rb);
         m_ra = lfsr_step(m_ra);
         m_rb = lfsr_step(m_rb);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input bit rnd_pause, input int restart_at, input int rst_at, input bit chk_first);
      int          idx = 0;
      int          hold = 0;
      int          budget = 0;
      bit          entry3_done = 0;
      bit          p;
      int          ex;
      logic [31:0] e1, e2;

      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check_eq("accept_val", 32'(bus.val), 32'd0);
      check_eq("accept_busy", 32'(bus.busy), 32'd1);
      check_eq("accept_cnt", bus.vec_cnt, 32'd0);

      while (idx < N && budget < 400) begin
         budget++;
         p = 1'b0;
         if (rnd_pause) begin
            if (idx == 3 && !entry3_done) begin
               hold        = 5;
               entry3_done = 1;
            end
            if (hold > 0) begin
               p = 1'b1;
               hold--;
            end else begin
               p = ($urandom_range(0, 3) == 0);
            end
         end
         bus.pause = p;
         bus.start = (idx == restart_at);
         if (idx == rst_at) begin
            rst       = 1'b1;
            bus.start = 1'b1;
            bus.pause = 1'b0;
            tick();
            rst       = 1'b0;
            bus.start = 1'b0;
            check_eq("rst_val", 32'(bus.val), 32'd0);
            check_eq("rst_busy", 32'(bus.busy), 32'd0);
            check_eq("rst_cnt", bus.vec_cnt, 32'd0);
            check_eq("rst_x1", bus.x1, 32'd0);
            tick();
            check_eq("rst_idle_busy", 32'(bus.busy), 32'd0);
            check_eq("rst_idle_val", 32'(bus.val), 32'd0);
            return;
         end
         tick();
         if (p) begin
            check_eq("pause_val", 32'(bus.val), 32'd0);
         end else begin
            check_eq("gen_val", 32'(bus.val), 32'd1);
            next_expected(idx, e1, e2);
            check_eq($sformatf("x1[%0d]", idx), bus.x1, e1);
            check_eq($sformatf("x2[%0d]", idx), bus.x2, e2);
            if (idx >= 8) begin
               ex = int'(bus.x1[30:23]);
               check_eq("x1_exp_range", 32'(ex >= 95 && ex <= 158), 32'd1);
               ex = int'(bus.x2[30:23]);
               check_eq("x2_exp_range", 32'(ex >= 95 && ex <= 158), 32'd1);
            end
            if (chk_first && idx == 8) check_eq("first_rand_x1", bus.x1, 32'h2F800001);
            if (chk_first && idx == 8) check_eq("first_rand_x2", bus.x2, 32'hCF7FFFFE);
            if (chk_first && idx == 9) check_eq("second_rand_x1", bus.x1, 32'hAFA00003);
            idx++;
         end
         check_eq("vec_cnt", bus.vec_cnt, 32'(idx));
         check_eq("run_busy", 32'(bus.busy), 32'd1);
      end
      bus.pause = 1'b0;
      bus.start = 1'b0;
      check_eq("run_budget", 32'(idx), 32'(N));

      for (int k = 0; k < PL; k++) begin
         bus.pause = 1'($urandom_range(0, 1));
         tick();
         check_eq("drain_val", 32'(bus.val), 32'd0);
         check_eq("drain_over", 32'(bus.over), 32'd0);
      end
      bus.pause = 1'b0;
      tick();
      check_eq("over_pulse", 32'(bus.over), 32'd1);
      check_eq("over_val", 32'(bus.val), 32'd0);
      check_eq("final_cnt", bus.vec_cnt, 32'(N));
      check_eq("over_busy", 32'(bus.busy), 32'd1);
      tick();
      check_eq("over_fall", 32'(bus.over), 32'd0);
      check_eq("busy_fall", 32'(bus.busy), 32'd0);
      check_eq("idle_cnt_hold", bus.vec_cnt, 32'(N));
   endtask

   initial begin
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.pause = 1'b0;
      repeat (3) tick();
      check_eq("reset_x1", bus.x1, 32'd0);
      check_eq("reset_x2", bus.x2, 32'd0);
      check_eq("reset_val", 32'(bus.val), 32'd0);
      check_eq("reset_over", 32'(bus.over), 32'd0);
      check_eq("reset_busy", 32'(bus.busy), 32'd0);
      check_eq("reset_cnt", bus.vec_cnt, 32'd0);
      rst = 1'b0;
      repeat (5) begin
         tick();
         check_eq("idle_val", 32'(bus.val), 32'd0);
         check_eq("idle_busy", 32'(bus.busy), 32'd0);
      end

      model_reset();
      run(1'b0, -1, -1, 1'b1);
      run(1'b1, 11, -1, 1'b0);
      run(1'b0, -1, 12, 1'b0);
      model_reset();
      run(1'b0, -1, -1, 1'b1);
      run(1'b1, 5, -1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
